cpu_sequencer: RTL

- Multi-cycle control FSM that sequences the processor datapath: instruction fetch, decode, execute, memory access, and writeback.
- Drives the program-counter advance/jump strobes, IR load, register write and data-memory strobes.
- Replaces fixed-interval PC stepping with per-instruction-class timing.
- Sits between the instruction decoder, PC, register file and data memory.

---
 rtl/seq_pkg.sv | 25 ++
 rtl/cpu_sequencer_if.sv | 35 +++
 rtl/seq_timeout_timer.sv | 29 ++
 rtl/cpu_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the multi-cycle CPU sequencer: FSM states and decoded
// instruction classes.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_LOAD   = 2'd1,
    OP_STORE  = 2'd2,
    OP_BRANCH = 2'd3
  } op_class_t;

  // MEM_TIMEOUT is limited to 1..255, so 8 bits always hold the wait count
  localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Decoder/datapath handshake bundle for cpu_sequencer: decoded instruction
// info and memory status in, datapath strobes and status out.
interface cpu_sequencer_if
  import seq_pkg::*;
#(
  parameter int unsigned CW = 16
);
  logic          start;
  op_class_t     op_class;
  logic          halt_instr;
  logic          branch_taken;
  logic          mem_ready;
  logic          pc_inc;
  logic          pc_load;
  logic          ir_load;
  logic          reg_we;
  logic          mem_re;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] instr_count;

  modport master (
    input  start, op_class, halt_instr, branch_taken, mem_ready,
    output pc_inc, pc_load, ir_load, reg_we, mem_re, mem_we,
           busy, done, err, instr_count
  );

  modport slave (
    output start, op_class, halt_instr, branch_taken, mem_ready,
    input  pc_inc, pc_load, ir_load, reg_we, mem_re, mem_we,
           busy, done, err, instr_count
  );
endinterface

// File: rtl/seq_timeout_timer.sv
// Wait-cycle timer for data-memory accesses; flags expiry once the count
// reaches MEM_TIMEOUT-1.
module seq_timeout_timer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired = (count == TIMER_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback with
// per-class timing, PC strobes, a retire counter and a sticky memory timeout.
module cpu_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned D           = 12,
  parameter int unsigned CW          = 16,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input logic             clk,
  input logic             reset,
  cpu_sequencer_if.master bus
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || D < 1) begin : g_param_check
    $error("cpu_sequencer: MEM_TIMEOUT must be 1..255 and D non-zero");
  end

  state_t          state;
  state_t          state_next;
  op_class_t       op;
  logic            timer_expired;
  logic            pc_inc;
  logic            pc_load;
  logic            ir_load;
  logic            reg_we;
  logic            mem_re;
  logic            mem_we;
  logic            err;
  logic [CW-1:0]   instr_count;

  assign op = bus.op_class;

  seq_timeout_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == EXEC),
    .count_en(state == MEM && !bus.mem_ready),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = FETCH;
      FETCH:   state_next = DECODE;
      DECODE:  state_next = bus.halt_instr ? HALT : EXEC;
      EXEC: begin
        unique case (op)
          OP_ALU:             state_next = WB;
          OP_LOAD, OP_STORE:  state_next = MEM;
          OP_BRANCH:          state_next = FETCH;
        endcase
      end
      // a completing access takes priority over a same-cycle timeout
      MEM: begin
        if (bus.mem_ready) begin
          state_next = (op == OP_LOAD) ? WB : FETCH;
        end else if (timer_expired) begin
          state_next = HALT;
        end
      end
      WB:      state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    ir_load = 1'b0;
    reg_we  = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      FETCH: ir_load = 1'b1;
      EXEC: begin
        if (op == OP_BRANCH) begin
          pc_load = bus.branch_taken;
          pc_inc  = !bus.branch_taken;
        end
      end
      MEM: begin
        mem_re = (op == OP_LOAD);
        mem_we = (op == OP_STORE);
        pc_inc = (op == OP_STORE) && bus.mem_ready;
      end
      WB: begin
        reg_we = 1'b1;
        pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err         <= 1'b0;
      instr_count <= '0;
    end else begin
      if (state == MEM && !bus.mem_ready && timer_expired) begin
        err <= 1'b1;
      end
      if (pc_inc || pc_load) begin
        instr_count <= instr_count + CW'(1);
      end
    end
  end

  assign bus.pc_inc      = pc_inc;
  assign bus.pc_load     = pc_load;
  assign bus.ir_load     = ir_load;
  assign bus.reg_we      = reg_we;
  assign bus.mem_re      = mem_re;
  assign bus.mem_we      = mem_we;
  assign bus.busy        = (state != IDLE) && (state != HALT);
  assign bus.done        = (state == HALT);
  assign bus.err         = err;
  assign bus.instr_count = instr_count;

endmodule
